// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: clears the register file after reset, then round-robins its write port between ALU and load writeback
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic last_grant, g0, g1, grant, last_clear;
  // No grant while rst is high, so a requester never sees a ready that reset then discards.
  always_comb begin
    g0 = state == RUN && !rst && req0_valid && (!req1_valid || last_grant);
    g1 = state == RUN && !rst && req1_valid && (!req0_valid || !last_grant);
    grant = g0 || g1;
    sel_addr = g1 ? req1_addr : req0_addr;
    sel_data = g1 ? req1_data : req0_data;
    last_clear = cnt == ADDR_WIDTH'(NUM_REGS - 1);
    state_n = (state == INIT && last_clear) ? RUN : state;
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  always_ff @(posedge clk)
    state <= rst ? INIT : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      last_grant <= 1'b1;
      rf_write_en <= 1'b0;
      rf_write_address <= '0;
      rf_write_data <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      rf_write_en <= 1'b1;
      rf_write_address <= cnt;
      rf_write_data <= '0;
      cnt <= cnt + 1'b1;
      init_done <= last_clear;
    end else begin
      rf_write_en <= grant && !(ZERO_REG_PROTECT != 0 && sel_addr == '0);
      if (grant) begin
        rf_write_address <= sel_addr;
        rf_write_data <= sel_data;
        last_grant <= g1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table plus reset sequences, expected writes queued at drive time and checked one cycle later
module tb_regfile_write_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [4:0] req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_data = 0, req1_data = 0;
  logic req0_ready, req1_ready, rf_write_en, init_done;
  logic [4:0] rf_write_address;
  logic [31:0] rf_write_data;
  logic np_r0, np_r1, np_en, np_done;
  logic [4:0] np_addr;
  logic [31:0] np_data;
  int total = 0;
  int bad = 0;
  logic [31:0] rf_m [32];

  typedef struct {
    logic v0; logic [4:0] a0; logic [31:0] d0;
    logic v1; logic [4:0] a1; logic [31:0] d1;
    logic r0; logic r1; logic en; logic [4:0] wa; logic [31:0] wd; logic enp;
  } vec_t;
  typedef struct {
    logic en; logic [4:0] a; logic [31:0] d; logic enp; logic done;
  } wr_t;
  wr_t q[$];
  vec_t vt[16];

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_write_en(rf_write_en), .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
    .init_done(init_done)
  );

  regfile_write_arbiter #(.ZERO_REG_PROTECT(0)) dut_np (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(np_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(np_r1),
    .rf_write_en(np_en), .rf_write_address(np_addr), .rf_write_data(np_data),
    .init_done(np_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)
      for (int i = 0; i < 32; i++) rf_m[i] <= 32'hFFFF_FFFF;
    else if (rf_write_en)
      rf_m[rf_write_address] <= rf_write_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic r0, input logic r1, input logic en,
                              input logic [4:0] wa, input logic [31:0] wd, input logic enp);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.en = en; v.wa = wa; v.wd = wd; v.enp = enp;
    return v;
  endfunction

  task automatic cycle(input logic er0, input logic er1, input logic een, input logic [4:0] ea,
                       input logic [31:0] ed, input logic eenp, input logic edone);
    wr_t w;
    @(negedge clk);
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, er0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, er1});
    chk("np_req_ready", {30'b0, np_r1, np_r0}, {30'b0, er1, er0});
    w.en = een; w.a = ea; w.d = ed; w.enp = eenp; w.done = edone;
    q.push_back(w);
    @(posedge clk);
    #1;
    w = q.pop_front();
    chk("rf_write_en", {31'b0, rf_write_en}, {31'b0, w.en});
    chk("rf_write_address", {27'b0, rf_write_address}, {27'b0, w.a});
    chk("rf_write_data", rf_write_data, w.d);
    chk("init_done", {31'b0, init_done}, {31'b0, w.done});
    chk("np_write_en", {31'b0, np_en}, {31'b0, w.enp});
    chk("np_write_address", {27'b0, np_addr}, {27'b0, w.a});
  endtask

  task automatic do_clear(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 5'(i), 32'h0, 1'b1, i == 31);
  endtask

  task automatic reset_check(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_en"}, {31'b0, rf_write_en}, 32'h0);
    chk({tag, "_addr"}, {27'b0, rf_write_address}, 32'h0);
    chk({tag, "_data"}, rf_write_data, 32'h0);
    chk({tag, "_done"}, {30'b0, np_done, init_done}, 32'h0);
  endtask

  initial begin
    vt[0]  = mk(1, 7, 32'hA,         1, 7, 32'hB,         1, 0, 1, 7, 32'hA,         1);
    vt[1]  = mk(0, 0, 32'h0,         1, 7, 32'hB,         0, 1, 1, 7, 32'hB,         1);
    vt[2]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 7, 32'hB,         0);
    vt[3]  = mk(1, 5, 32'h12345678,  0, 0, 32'h0,         1, 0, 1, 5, 32'h12345678,  1);
    vt[4]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 5, 32'h12345678,  0);
    vt[5]  = mk(0, 0, 32'h0,         1, 20, 32'h55,       0, 1, 1, 20, 32'h55,       1);
    vt[6]  = mk(1, 1, 32'h101,       1, 9, 32'h909,       1, 0, 1, 1, 32'h101,       1);
    vt[7]  = mk(1, 2, 32'h202,       1, 9, 32'h909,       0, 1, 1, 9, 32'h909,       1);
    vt[8]  = mk(1, 2, 32'h202,       1, 10, 32'hA0A,      1, 0, 1, 2, 32'h202,       1);
    vt[9]  = mk(1, 3, 32'h303,       1, 10, 32'hA0A,      0, 1, 1, 10, 32'hA0A,      1);
    vt[10] = mk(1, 3, 32'h303,       1, 11, 32'hB0B,      1, 0, 1, 3, 32'h303,       1);
    vt[11] = mk(0, 0, 32'h0,         1, 11, 32'hB0B,      0, 1, 1, 11, 32'hB0B,      1);
    vt[12] = mk(0, 0, 32'h0,         1, 0, 32'hDEADBEEF,  0, 1, 0, 0, 32'hDEADBEEF,  1);
    vt[13] = mk(1, 0, 32'h1111,      1, 4, 32'h44,        1, 0, 0, 0, 32'h1111,      1);
    vt[14] = mk(0, 0, 32'h0,         1, 4, 32'h44,        0, 1, 1, 4, 32'h44,        1);
    vt[15] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 4, 32'h44,        0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_en", {31'b0, rf_write_en}, 32'h0);
    chk("reset_addr", {27'b0, rf_write_address}, 32'h0);
    chk("reset_data", rf_write_data, 32'h0);
    chk("reset_done", {31'b0, init_done}, 32'h0);
    chk("reset_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
    req0_valid = vt[0].v0; req0_addr = vt[0].a0; req0_data = vt[0].d0;
    req1_valid = vt[0].v1; req1_addr = vt[0].a1; req1_data = vt[0].d1;
    rst = 0;
    do_clear(32);

    for (int i = 0; i < 16; i++) begin
      req0_valid = vt[i].v0; req0_addr = vt[i].a0; req0_data = vt[i].d0;
      req1_valid = vt[i].v1; req1_addr = vt[i].a1; req1_data = vt[i].d1;
      cycle(vt[i].r0, vt[i].r1, vt[i].en, vt[i].wa, vt[i].wd, vt[i].enp, 1'b1);
    end
    chk("rf7_race", rf_m[7], 32'h0000_000B);
    chk("rf0_protected", rf_m[0], 32'h0);
    chk("rf4", rf_m[4], 32'h44);
    chk("rf20", rf_m[20], 32'h55);
    chk("rf11", rf_m[11], 32'hB0B);
    chk("rf6_cleared", rf_m[6], 32'h0);
    for (int r = 21; r < 32; r++) chk("rf_cleared", rf_m[r], 32'h0);

    req0_valid = 1; req0_addr = 3; req0_data = 32'h1;
    req1_valid = 1; req1_addr = 9; req1_data = 32'h2;
    rst = 1;
    reset_check("run_reset");
    rst = 0;
    do_clear(32);

    rst = 1;
    reset_check("reset_again");
    rst = 0;
    do_clear(10);
    rst = 1;
    reset_check("mid_clear_reset");
    rst = 0;
    do_clear(32);

    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 1; req1_addr = 12; req1_data = 32'hC;
    cycle(1'b0, 1'b1, 1'b1, 5'd12, 32'hC, 1'b1, 1'b1);
    req1_valid = 0;
    cycle(1'b0, 1'b0, 1'b0, 5'd12, 32'hC, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
